des_round_combine: RTL and testbench

DES_ROUND_COMBINE -- requirements
Module: des_round_combine

---
 rtl/des_round_combine.sv | 107 ++++++++++
 tb/tb_des_round_combine.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/des_round_combine.sv
// DES round combine: applies the P permutation to the S-box outputs, mixes it
// into the Feistel halves and queues the next-round halves in a 2-entry FIFO.
module des_round_combine #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [31:0]           sbox_out,
   input  logic [DATA_WIDTH-1:0] l_in,
   input  logic [DATA_WIDTH-1:0] r_in,
   input  logic [3:0]            round_in,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [DATA_WIDTH-1:0] l_out,
   output logic [DATA_WIDTH-1:0] r_out,
   output logic [3:0]            round_out,
   output logic                  out_valid,
   input  logic                  out_ready
);

   typedef struct packed {
      logic [3:0]            rnd;
      logic [DATA_WIDTH-1:0] l;
      logic [DATA_WIDTH-1:0] r;
   } entry_t;

   // Standard DES P table, 1-indexed with bit 1 as the MSB.
   localparam int unsigned P_TBL [32] = '{
      16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
       2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25
   };

   entry_t      mem_q [DEPTH];
   entry_t      mem_d [DEPTH];
   logic        wr_ptr_q, wr_ptr_d;
   logic        rd_ptr_q, rd_ptr_d;
   logic [1:0]  count_q, count_d;

   logic [31:0] f;
   entry_t      new_entry;
   entry_t      head;
   logic        push;
   logic        pop;

   assign in_ready  = (count_q < 2'd2);
   assign out_valid = (count_q != 2'd0);
   assign head      = mem_q[rd_ptr_q];
   // Gate the head with out_valid so an empty buffer never shows old data.
   assign l_out     = out_valid ? head.l   : '0;
   assign r_out     = out_valid ? head.r   : '0;
   assign round_out = out_valid ? head.rnd : '0;

   always_comb begin
      f = '0;
      for (int unsigned j = 0; j < 32; j++) begin
         f[31-j] = sbox_out[32-P_TBL[j]];
      end

      new_entry     = '0;
      new_entry.rnd = round_in;
      if (round_in == 4'd15) begin
         new_entry.l = l_in ^ f;
         new_entry.r = r_in;
      end else begin
         new_entry.l = r_in;
         new_entry.r = l_in ^ f;
      end

      push = in_valid && in_ready;
      pop  = out_valid && out_ready;

      mem_d = mem_q;
      if (push) begin
         mem_d[wr_ptr_q] = new_entry;
      end

      wr_ptr_d = push ? ~wr_ptr_q : wr_ptr_q;
      rd_ptr_d = pop  ? ~rd_ptr_q : rd_ptr_q;

      count_d = count_q;
      if (push && !pop) begin
         count_d = count_q + 2'd1;
      end else if (pop && !push) begin
         count_d = count_q - 2'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q  <= '0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         count_q  <= count_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= mem_d[i];
         end
      end
   end

endmodule

// File: tb/tb_des_round_combine.sv
// Directed bench for des_round_combine: hand-computed round results, FIFO
// backpressure, back-to-back streaming and mid-operation reset.
module tb_des_round_combine;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] sbox_out;
   logic [31:0] l_in;
   logic [31:0] r_in;
   logic [3:0]  round_in;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] l_out;
   logic [31:0] r_out;
   logic [3:0]  round_out;
   logic        out_valid;
   logic        out_ready;

   int tests = 0;
   int fails = 0;

   des_round_combine #(.DATA_WIDTH(32), .DEPTH(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .sbox_out  (sbox_out),
      .l_in      (l_in),
      .r_in      (r_in),
      .round_in  (round_in),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .l_out     (l_out),
      .r_out     (r_out),
      .round_out (round_out),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [31:0] sb, input logic [31:0] l, input logic [31:0] r,
                        input logic [3:0] rnd, input logic vld);
      sbox_out = sb;
      l_in     = l;
      r_in     = r;
      round_in = rnd;
      in_valid = vld;
   endtask

   task automatic chk_head(input string tag, input logic [31:0] l, input logic [31:0] r,
                           input logic [3:0] rnd);
      chk({tag, ".valid"}, 64'(out_valid), 64'd1);
      chk({tag, ".l"},     64'(l_out),     64'(l));
      chk({tag, ".r"},     64'(r_out),     64'(r));
      chk({tag, ".round"}, 64'(round_out), 64'(rnd));
   endtask

   initial begin
      rst       = 1'b1;
      out_ready = 1'b1;
      drive(32'h0, 32'h0, 32'h0, 4'd0, 1'b0);
      step();
      step();
      chk("rst.out_valid", 64'(out_valid), 64'd0);
      chk("rst.in_ready",  64'(in_ready),  64'd1);
      chk("rst.l_out",     64'(l_out),     64'd0);
      chk("rst.r_out",     64'(r_out),     64'd0);
      chk("rst.round_out", 64'(round_out), 64'd0);

      // First push on the first edge after reset release.
      rst = 1'b0;
      drive(32'h8000_0000, 32'h0, 32'h1234_5678, 4'd0, 1'b1);
      step();
      chk_head("vecA", 32'h1234_5678, 32'h0080_0000, 4'd0);
      chk("vecA.in_ready", 64'(in_ready), 64'd1);
      drive(32'h8000_0000, 32'h0, 32'h1234_5678, 4'd15, 1'b1);
      step();
      chk_head("vecB", 32'h0080_0000, 32'h1234_5678, 4'd15);
      drive(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 4'd3, 1'b1);
      step();
      chk_head("vecC", 32'h0, 32'h0, 4'd3);
      drive(32'h0000_0001, 32'h0, 32'h0, 4'd7, 1'b1);
      step();
      chk_head("vecP32", 32'h0, 32'h0000_0800, 4'd7);
      drive(32'h4000_0000, 32'h0, 32'h0, 4'd2, 1'b1);
      step();
      chk_head("vecP2", 32'h0, 32'h0000_8000, 4'd2);
      drive(32'h0, 32'h0, 32'h0, 4'd0, 1'b0);
      step();
      chk("drain.out_valid", 64'(out_valid), 64'd0);

      // Backpressure: third word held off until the first pop.
      out_ready = 1'b0;
      drive(32'h0, 32'd1, 32'd2, 4'd1, 1'b1);
      step();
      chk("bp1.in_ready", 64'(in_ready), 64'd1);
      chk_head("bp1", 32'd2, 32'd1, 4'd1);
      drive(32'h0, 32'd3, 32'd4, 4'd2, 1'b1);
      step();
      chk("bp2.in_ready", 64'(in_ready), 64'd0);
      chk_head("bp2", 32'd2, 32'd1, 4'd1);
      drive(32'h0, 32'd5, 32'd6, 4'd3, 1'b1);
      step();
      chk("bp3.in_ready", 64'(in_ready), 64'd0);
      chk_head("bp3.hold", 32'd2, 32'd1, 4'd1);
      out_ready = 1'b1;
      step();
      chk("bp4.in_ready", 64'(in_ready), 64'd1);
      chk_head("bp4", 32'd4, 32'd3, 4'd2);
      step();
      chk_head("bp5", 32'd6, 32'd5, 4'd3);
      drive(32'h0, 32'h0, 32'h0, 4'd0, 1'b0);
      step();
      chk("bp6.out_valid", 64'(out_valid), 64'd0);

      // Streaming at count 1: one pop and one push every cycle.
      out_ready = 1'b0;
      drive(32'h0, 32'hA0, 32'hB0, 4'd9, 1'b1);
      step();
      chk_head("st0", 32'hB0, 32'hA0, 4'd9);
      out_ready = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         drive(32'h0, 32'(k * 16), 32'(k), 4'(k % 15), 1'b1);
         step();
         chk_head($sformatf("st%0d", k), 32'(k), 32'(k * 16), 4'(k % 15));
      end
      drive(32'h0, 32'h0, 32'h0, 4'd0, 1'b0);
      step();
      chk("st.end.out_valid", 64'(out_valid), 64'd0);

      // Reset with two entries buffered, push and pop requested the same cycle.
      out_ready = 1'b0;
      drive(32'h0, 32'h11, 32'h22, 4'd4, 1'b1);
      step();
      drive(32'h0, 32'h33, 32'h44, 4'd5, 1'b1);
      step();
      chk("rf.full.in_ready", 64'(in_ready), 64'd0);
      rst       = 1'b1;
      out_ready = 1'b1;
      drive(32'h0, 32'h55, 32'h66, 4'd6, 1'b1);
      step();
      chk("rf.out_valid", 64'(out_valid), 64'd0);
      chk("rf.in_ready",  64'(in_ready),  64'd1);
      chk("rf.l_out",     64'(l_out),     64'd0);
      rst = 1'b0;
      drive(32'h0, 32'h0, 32'h0, 4'd0, 1'b0);
      step();
      chk("rf.nostale", 64'(out_valid), 64'd0);
      drive(32'h0, 32'h77, 32'h88, 4'd8, 1'b1);
      step();
      chk_head("rf.new", 32'h88, 32'h77, 4'd8);
      drive(32'h0, 32'h0, 32'h0, 4'd0, 1'b0);
      step();
      chk("rf.drain", 64'(out_valid), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
